// File: rtl/dmac_arb_pkg.sv
// rtl/dmac_arb_pkg.sv - shared state encoding and AXI field widths for the DMAC read arbiter
package dmac_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } arb_state_e;

    localparam int AXI_LEN_W  = 4;
    localparam int AXI_RESP_W = 2;

endpackage

// File: rtl/dmac_rr_picker.sv
// rtl/dmac_rr_picker.sv - one-hot requester picker, round-robin by default; DMAC_RDARB_FIXED_PRIO_EN selects fixed priority
module dmac_rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] pick
);

`ifdef DMAC_RDARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Descending scan so the lowest requesting index is the final write.
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = N_REQ'(1) << i;
            end
        end
    end
`else
    // Search starts one past the previous owner and wraps, so the owner goes last.
    always_comb begin
        int   idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dmac_rd_arbiter.sv
// rtl/dmac_rd_arbiter.sv - shares one AXI AR/R port between DMA read requesters one burst at a time; DMAC_RDARB_FIXED_PRIO_EN selects fixed priority
module dmac_rd_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              m_arvalid,
    output logic [N_REQ-1:0]              m_arready,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [N_REQ*ID_WIDTH-1:0]     m_arid,
    input  logic [N_REQ*AXI_LEN_W-1:0]    m_arlen,
    output logic [N_REQ-1:0]              m_rvalid,
    input  logic [N_REQ-1:0]              m_rready,
    output logic [DATA_WIDTH-1:0]         m_rdata,
    output logic [ID_WIDTH-1:0]           m_rid,
    output logic [AXI_RESP_W-1:0]         m_rresp,
    output logic                          m_rlast,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [ADDR_WIDTH-1:0]         s_araddr,
    output logic [ID_WIDTH-1:0]           s_arid,
    output logic [AXI_LEN_W-1:0]          s_arlen,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic [ID_WIDTH-1:0]           s_rid,
    input  logic [AXI_RESP_W-1:0]         s_rresp,
    input  logic                          s_rlast,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state;
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] last_grant;

    dmac_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (m_arvalid),
        .last_grant (last_grant),
        .pick       (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Reset parks last_grant on the top index so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant      <= '0;
            g_idx      <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (|m_arvalid) begin
                        grant <= pick;
                        g_idx <= pick_idx;
                        state <= S_AR;
                    end
                end
                S_AR: begin
                    if (s_arvalid && s_arready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        state      <= S_IDLE;
                        grant      <= '0;
                        last_grant <= g_idx;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arid    = '0;
        s_arlen   = '0;
        m_arready = '0;
        s_rready  = 1'b0;
        m_rvalid  = '0;
        case (state)
            S_AR: begin
                s_arvalid = m_arvalid[g_idx];
                s_araddr  = m_araddr[int'(g_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                s_arid    = m_arid[int'(g_idx)*ID_WIDTH +: ID_WIDTH];
                s_arlen   = m_arlen[int'(g_idx)*AXI_LEN_W +: AXI_LEN_W];
                m_arready = grant & {N_REQ{s_arready}};
            end
            S_R: begin
                s_rready = m_rready[g_idx];
                m_rvalid = grant & {N_REQ{s_rvalid}};
            end
            default: begin
            end
        endcase
    end

    // R payload is a plain broadcast; only the per-requester valid is steered.
    assign m_rdata = s_rdata;
    assign m_rid   = s_rid;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign busy    = (state != S_IDLE);

endmodule
